rffp_int_encoder: RTL and testbench
===================================

Name: rffp_int_encoder

Overview:
- Converts a signed two's-complement integer into the team's RFFP sign/exponent/mantissa word.
- RFFP word layout: bit [E+M] is the sign, bits [E+M-1:M] are the unsigned exponent, bits [M-1:0] are the unsigned mantissa with no hidden bit. Value = (-1)^sign × mantissa × 2^exponent.
- This is the producer side of the format the RFFP adder consumes. It sits at the datapath ingress, ahead of the RFFP arithmetic units.
- Normalization is iterative, one shift per clock, with valid/ready handshakes on both sides.

Parameters:
- RFFP_EXP_WIDTH, 8, exponent field width E
- RFFP_MAN_WIDTH, 8, mantissa field width M
- INT_WIDTH, 32, signed integer input width (must be > RFFP_MAN_WIDTH)
- IN_OUT_WIDTH, RFFP_EXP_WIDTH+RFFP_MAN_WIDTH, MSB index of the RFFP word

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_data is valid
- in_ready  out  1  encoder can accept a new input
- in_data  in  INT_WIDTH  signed integer to encode
- out_valid  out  1  out_data/out_ovf are valid
- out_ready  in  1  consumer accepts the output
- out_data  out  IN_OUT_WIDTH+1  RFFP result
- out_ovf  out  1  exponent saturated

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- While rst is asserted: state = IDLE, out_valid = 0, out_data = 0, out_ovf = 0, all internal registers = 0. After reset, in_ready = 1.
- Reset asserted mid-operation aborts the conversion immediately. No output is produced for the aborted input.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture sign = in_data[MSB] and mag = |in_data| as an INT_WIDTH-bit unsigned value. The most negative input gives mag = 2^(INT_WIDTH-1) exactly.
  - Also clear exp and rnd, then go to SHIFT.
- SHIFT:
  - If mag >= 2^M: rnd <= mag[0], mag <= mag >> 1, exp <= exp + 1.
  - Otherwise go to ROUND.
  - If exp already equals 2^E-1 and a further shift is required: set ovf, force mag = 2^M-1 and exp = 2^E-1, and go to DONE (rounding is skipped).
- ROUND:
  - If rnd = 1: mag <= mag + 1 (round half up, matching the adder).
  - If the incremented value equals 2^M: mag <= 2^(M-1) and exp <= exp + 1. If that increment would exceed 2^E-1, saturate as in SHIFT with ovf = 1.
  - Go to DONE.
- DONE:
  - out_valid = 1. out_data = {sign, exp, mag[M-1:0]}. out_ovf = ovf.
  - All outputs are held stable until out_ready = 1. On that handshake, go to IDLE.
  - in_ready = 0 in every state except IDLE.
- Latency: let k = bit length of mag and s = max(0, k-M). out_valid asserts s+3 cycles after the accepting edge. Throughput is one result per s+4 cycles minimum.
- Zero input encodes as all-zero, sign 0. Negative zero is never produced.
- Mantissa is not forced to have its MSB set. Values below 2^M keep exp = 0.
- in_data changes while in_ready = 0 are ignored. out_ready while out_valid = 0 is ignored.

Decomposition:
- Package rffp_pkg holds:
  - default widths;
  - typedef rffp_word_t;
  - the state enum (IDLE/SHIFT/ROUND/DONE);
  - functions rffp_pack(sign, exp, man) and int_abs().
- The adder and later RFFP blocks share this package.
- No sub-module is needed: a single FSM plus datapath registers.

Test Plan:
- E=8, M=8. Input 100 → out_data 0x00064, out_ovf 0, out_valid 3 cycles after accept.
- Input -300 → one shift (dropped bit 0) → out_data 0x10196 (sign 1, exp 1, man 150), 4-cycle latency.
- Input 511 → shift gives 255 with rnd 1 → round overflow → man 128, exp 2 → out_data 0x00280.
- Input -2^31 → out_data 0x11880 (exp 24, man 128), 27-cycle latency. Input 0 → out_data 0x00000.
- Build with E=4. Input 2^30 → out_data {0, 4'hF, 8'hFF}, out_ovf 1.
- Hold out_ready low for 5 cycles → out_data stable and in_ready 0 throughout. Assert rst mid-SHIFT → next cycle out_valid 0, in_ready 1, and a following input 7 encodes to 0x00007.

Source files
------------

// File: rtl/rffp_pkg.sv
// Shared RFFP definitions: default field widths, word type, encoder state
// enum and small packing / magnitude helpers used by the RFFP blocks.
package rffp_pkg;

    localparam int RFFP_EXP_W_DEF = 8;
    localparam int RFFP_MAN_W_DEF = 8;
    localparam int RFFP_INT_W_DEF = 32;

    // RFFP word at default widths: {sign, exp, man}
    typedef logic [RFFP_EXP_W_DEF+RFFP_MAN_W_DEF:0] rffp_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } rffp_state_e;

    // Packs sign/exponent/mantissa into the low (e_w+m_w+1) bits of a 64-bit
    // word. Callers pass zero-extended fields and keep the bits they need.
    function automatic logic [63:0] rffp_pack(
        input logic        sign,
        input logic [31:0] exp,
        input logic [31:0] man,
        input int          e_w,
        input int          m_w
    );
        logic [63:0] w;
        w = 64'(man) | (64'(exp) << m_w) | (64'(sign) << (e_w + m_w));
        return w;
    endfunction

    // Magnitude of a sign-extended 64-bit value. The most negative value of
    // any narrower input width is representable here, so no wrap occurs.
    function automatic logic [63:0] int_abs(input logic signed [63:0] v);
        logic [63:0] u;
        u = v;
        return u[63] ? (~u + 64'd1) : u;
    endfunction

endpackage

// File: rtl/rffp_int_encoder.sv
// Signed integer to RFFP encoder. The magnitude is normalised one right shift
// per clock until it fits the mantissa field, then rounded half-up on the
// last dropped bit. Exponent overflow saturates to the largest magnitude.
//
// state | meaning
// IDLE  | waiting for an input, in_ready high
// SHIFT | shifting magnitude right until it fits M bits
// ROUND | applying the half-up increment from the last dropped bit
// DONE  | result presented, held until out_ready
module rffp_int_encoder
    import rffp_pkg::*;
#(
    parameter int RFFP_EXP_WIDTH = RFFP_EXP_W_DEF,
    parameter int RFFP_MAN_WIDTH = RFFP_MAN_W_DEF,
    parameter int INT_WIDTH      = RFFP_INT_W_DEF,   // must exceed RFFP_MAN_WIDTH, below 64
    parameter int IN_OUT_WIDTH   = RFFP_EXP_WIDTH + RFFP_MAN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INT_WIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IN_OUT_WIDTH:0] out_data,
    output logic                  out_ovf
);

    localparam logic [INT_WIDTH-1:0]      MAN_FULL = INT_WIDTH'(1) << RFFP_MAN_WIDTH;
    localparam logic [INT_WIDTH-1:0]      MAN_SAT  = MAN_FULL - INT_WIDTH'(1);
    localparam logic [INT_WIDTH-1:0]      MAN_HALF = INT_WIDTH'(1) << (RFFP_MAN_WIDTH - 1);
    localparam logic [RFFP_EXP_WIDTH-1:0] EXP_MAX  = {RFFP_EXP_WIDTH{1'b1}};

    rffp_state_e               r_state;
    logic                      r_sign;
    logic [INT_WIDTH-1:0]      r_mag;
    logic [RFFP_EXP_WIDTH-1:0] r_exp;
    logic                      r_rnd;
    logic                      r_ovf;
    logic                      r_out_valid;

    logic signed [63:0]        w_in_ext;
    logic [63:0]               w_abs64;
    logic [INT_WIDTH-1:0]      w_mag_in;
    logic [INT_WIDTH-1:0]      w_mag_inc;
    logic                      w_need_shift;
    logic [63:0]               w_pack64;
    logic                      w_unused_bits;

    assign w_in_ext     = 64'(signed'(in_data));
    assign w_abs64      = int_abs(w_in_ext);
    assign w_mag_in     = w_abs64[INT_WIDTH-1:0];
    assign w_mag_inc    = r_mag + INT_WIDTH'(1);
    assign w_need_shift = (r_mag >= MAN_FULL);
    assign w_pack64     = rffp_pack(r_sign, 32'(r_exp), 32'(r_mag[RFFP_MAN_WIDTH-1:0]),
                                    RFFP_EXP_WIDTH, RFFP_MAN_WIDTH);
    assign w_unused_bits = ^{w_abs64[63:INT_WIDTH], w_pack64[63:IN_OUT_WIDTH+1]};

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    // Result fields only change outside DONE, so gating keeps the bus quiet
    // between results and stable while waiting for out_ready.
    assign out_data  = r_out_valid ? w_pack64[IN_OUT_WIDTH:0] : '0;
    assign out_ovf   = r_out_valid & r_ovf;

    // Encoder FSM with its datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_exp       <= '0;
            r_rnd       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign  <= in_data[INT_WIDTH-1];
                        r_mag   <= w_mag_in;
                        r_exp   <= '0;
                        r_rnd   <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_need_shift) begin
                        if (r_exp == EXP_MAX) begin
                            // no exponent headroom left: saturate, skip rounding
                            r_ovf       <= 1'b1;
                            r_mag       <= MAN_SAT;
                            r_exp       <= EXP_MAX;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_rnd <= r_mag[0];
                            r_mag <= r_mag >> 1;
                            r_exp <= r_exp + 1'b1;
                        end
                    end else begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    if (r_rnd) begin
                        if (w_mag_inc == MAN_FULL) begin
                            if (r_exp == EXP_MAX) begin
                                r_ovf <= 1'b1;
                                r_mag <= MAN_SAT;
                            end else begin
                                r_mag <= MAN_HALF;
                                r_exp <= r_exp + 1'b1;
                            end
                        end else begin
                            r_mag <= w_mag_inc;
                        end
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rffp_int_encoder.sv
// Bench for rffp_int_encoder: directed vector table, hold / reset sequences,
// a narrow-exponent instance for saturation, and randomized inputs checked
// against an arithmetic model of the encoding rules.
module tb_rffp_int_encoder;

    logic        clk;
    logic        rst;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_ovf_a;
    logic [31:0] in_data_a;
    logic [16:0] out_data_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_ovf_b;
    logic [31:0] in_data_b;
    logic [12:0] out_data_b;

    int n_cmp = 0;
    int n_bad = 0;

    rffp_int_encoder #(.RFFP_EXP_WIDTH(8), .RFFP_MAN_WIDTH(8), .INT_WIDTH(32)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .out_ovf(out_ovf_a)
    );

    rffp_int_encoder #(.RFFP_EXP_WIDTH(4), .RFFP_MAN_WIDTH(8), .INT_WIDTH(32)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_ovf(out_ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Encoding rules stated arithmetically: s = max(0, bitlen - M) dropped
    // bits, round half up on the last dropped bit, saturate past 2^E-1.
    function automatic void model(input longint v, input int e, input int m,
                                  output logic [16:0] word, output logic ovf,
                                  output int lat);
        longint mag, t, man;
        int     k, s, emax, ex;
        logic   sign;
        sign = (v < 0);
        mag  = (v < 0) ? -v : v;
        k = 0;
        t = mag;
        while (t != 0) begin k++; t = t >> 1; end
        s    = (k > m) ? k - m : 0;
        emax = (1 << e) - 1;
        ovf  = 1'b0;
        if (s > emax) begin
            ovf = 1'b1; man = (longint'(1) << m) - 1; ex = emax; lat = emax + 2;
        end else begin
            man = mag >> s;
            if (s > 0 && ((mag >> (s - 1)) & 1) == 1) man = man + 1;
            ex  = s;
            lat = s + 3;
            if (man == (longint'(1) << m)) begin
                man = longint'(1) << (m - 1);
                ex  = ex + 1;
                if (ex > emax) begin
                    ovf = 1'b1; man = (longint'(1) << m) - 1; ex = emax;
                end
            end
        end
        word = 17'((longint'(sign) << (e + m)) | (longint'(ex) << m) | man);
    endfunction

    // One full transaction on instance a (sel=0) or b (sel=1).
    task automatic run_check(input bit sel, input logic [31:0] v,
                             input logic [16:0] exp_d, input logic exp_ovf,
                             input int exp_lat, input int hold, input string nm);
        int n;
        int lat;
        n = 0;
        while (!(sel ? in_ready_b : in_ready_a) && n < 60) begin @(posedge clk); #1; n++; end
        if (n >= 60) check({nm, "_ready_timeout"}, 64'(sel ? in_ready_b : in_ready_a), 64'd1);
        if (sel) begin in_valid_b = 1'b1; in_data_b = v; end
        else     begin in_valid_a = 1'b1; in_data_a = v; end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        lat = 1;
        while (!(sel ? out_valid_b : out_valid_a) && lat < 300) begin @(posedge clk); #1; lat++; end
        check({nm, "_valid"}, 64'(sel ? out_valid_b : out_valid_a), 64'd1);
        check({nm, "_data"}, 64'(sel ? 17'(out_data_b) : out_data_a), 64'(exp_d));
        check({nm, "_ovf"}, 64'(sel ? out_ovf_b : out_ovf_a), 64'(exp_ovf));
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({nm, "_hold_data"}, 64'(sel ? 17'(out_data_b) : out_data_a), 64'(exp_d));
            check({nm, "_hold_in_ready"}, 64'(sel ? in_ready_b : in_ready_a), 64'd0);
        end
        if (sel) out_ready_b = 1'b1; else out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        out_ready_b = 1'b0;
        check({nm, "_valid_dropped"}, 64'(sel ? out_valid_b : out_valid_a), 64'd0);
    endtask

    typedef struct {
        logic [31:0] din;
        logic [16:0] dout;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [16:0] md;
        logic        mo;
        int          ml;
        int          seen;
        logic [31:0] rv;

        vecs[0] = '{32'd100,          17'h00064, 1'b0, 3};
        vecs[1] = '{-32'sd300,        17'h10196, 1'b0, 4};
        vecs[2] = '{32'd511,          17'h00280, 1'b0, 4};
        vecs[3] = '{32'h8000_0000,    17'h11880, 1'b0, 27};
        vecs[4] = '{32'd0,            17'h00000, 1'b0, 3};
        vecs[5] = '{32'd7,            17'h00007, 1'b0, 3};
        vecs[6] = '{32'd256,          17'h00180, 1'b0, 4};
        vecs[7] = '{32'hFFFF_FFFF,    17'h10001, 1'b0, 3};
        vecs[8] = '{32'd255,          17'h000FF, 1'b0, 3};
        vecs[9] = '{32'h7FFF_FFFF,    17'h01880, 1'b0, 26};

        in_valid_a = 0; in_data_a = 0; out_ready_a = 0;
        in_valid_b = 0; in_data_b = 0; out_ready_b = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_out_data", 64'(out_data_a), 64'd0);
        check("rst_out_ovf", 64'(out_ovf_a), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready_a), 64'd1);

        // out_ready with nothing pending must not produce a result
        out_ready_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_out_ready_ignored", 64'(out_valid_a), 64'd0);
        out_ready_a = 1'b0;

        for (int i = 0; i < 10; i++)
            run_check(0, vecs[i].din, vecs[i].dout, vecs[i].ovf, vecs[i].lat, 0,
                      $sformatf("vec%0d", i));

        // back-pressure: result held for 5 cycles
        model(longint'(1000), 8, 8, md, mo, ml);
        run_check(0, 32'd1000, md, mo, ml, 5, "hold");

        // reset during SHIFT aborts the conversion
        in_valid_a = 1'b1; in_data_a = 32'h8000_0000;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready_a), 64'd1);
        check("abort_out_valid", 64'(out_valid_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_next_out_valid", 64'(out_valid_a), 64'd0);
        check("abort_next_in_ready", 64'(in_ready_a), 64'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid_a) seen++;
        end
        check("abort_no_output", 64'(seen), 64'd0);
        run_check(0, 32'd7, 17'h00007, 1'b0, 3, 0, "after_rst");

        // narrow exponent: shift saturation, rounding saturation, plain value
        run_check(1, 32'h4000_0000, 17'h00FFF, 1'b1, 17, 0, "e4_shift_sat");
        model(longint'(32'h007F_C000), 4, 8, md, mo, ml);
        run_check(1, 32'h007F_C000, md, mo, ml, 0, "e4_round_sat");
        run_check(1, 32'd100, 17'h00064, 1'b0, 3, 0, "e4_small");

        for (int i = 0; i < 200; i++) begin
            rv = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rv = -rv;
            model(longint'(signed'(rv)), 8, 8, md, mo, ml);
            run_check(0, rv, md, mo, ml, $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
